dram_timing_ctrl: RTL and testbench

Timing-enforcement counterpart of the DRAM command FSM. Watches the FSM's current and next command state and produces the per-command timing-satisfied flags (`tACT_done`, `tRD_done`, `tWR_done`, `tPRE_done`, `tREF_done`), the power-up `init_done`, and the periodic refresh request `rf_req`. It sits between the command FSM and the memory-controller top level inside the DRAM controller, and it is the only source of DRAM timing in the design.

---
 rtl/dram_timing_ctrl.sv | 160 ++++++++++++++++
 tb/tb_dram_timing_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_timing_ctrl.sv
// DRAM command timing enforcement: per-command done flags, power-up wait and refresh scheduling.
// The refresh scheduler (interval counter, refresh debt, rf_req) is built only with `DRAM_TIMING_REFRESH_EN.
package dram_pack;
  typedef enum logic [2:0] {
    CMD_IDLE      = 3'd0,
    CMD_INIT      = 3'd1,
    CMD_ACTIVATE  = 3'd2,
    CMD_READ      = 3'd3,
    CMD_WRITE     = 3'd4,
    CMD_PRECHARGE = 3'd5,
    CMD_REFRESH   = 3'd6,
    CMD_MODE      = 3'd7
  } cmd_fsm_t;
endpackage

module dram_timing_ctrl
  import dram_pack::*;
#(
  parameter int unsigned tINIT = 200,
  parameter int unsigned tRCD  = 4,
  parameter int unsigned tRL   = 8,
  parameter int unsigned tWL   = 10,
  parameter int unsigned tRP   = 4,
  parameter int unsigned tRFC  = 32,
  parameter int unsigned tREFI = 1560
) (
  input  logic     CLK,
  input  logic     RST,
  input  cmd_fsm_t cmd_state,
  input  cmd_fsm_t ncmd_state,
  input  logic     init_req,
  output logic     init_done,
  output logic     tACT_done,
  output logic     tRD_done,
  output logic     tWR_done,
  output logic     tPRE_done,
  output logic     tREF_done,
  output logic     rf_req
);

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned T_MAX  = max_of(max_of(max_of(tRCD, tRL), max_of(tWL, tRP)), tRFC);
  localparam int unsigned CNT_W  = $clog2(T_MAX) + 1;
  localparam int unsigned INIT_W = $clog2(tINIT) + 1;

  if (tINIT < 1 || tRCD < 1 || tRL < 1 || tWL < 1 || tRP < 1 || tRFC < 1 || tREFI < 2) begin : g_param_check
    $error("dram_timing_ctrl: timing parameters out of range");
  end

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [INIT_W-1:0] init_cnt;
  logic [INIT_W-1:0] init_cnt_next;
  logic              init_done_next;

  // Elapsed cycles in the current command state; restarts whenever the FSM changes state.
  always_comb begin
    cnt_next = '0;
    if (ncmd_state == cmd_state) begin
      cnt_next = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    end
  end

  // Done flags: only the flag of the current state can be high.
  always_comb begin
    tACT_done = 1'b0;
    tRD_done  = 1'b0;
    tWR_done  = 1'b0;
    tPRE_done = 1'b0;
    tREF_done = 1'b0;
    case (cmd_state)
      CMD_ACTIVATE:  tACT_done = (32'(cnt) >= tRCD - 32'd1);
      CMD_READ:      tRD_done  = (32'(cnt) >= tRL - 32'd1);
      CMD_WRITE:     tWR_done  = (32'(cnt) >= tWL - 32'd1);
      CMD_PRECHARGE: tPRE_done = (32'(cnt) >= tRP - 32'd1);
      CMD_REFRESH:   tREF_done = (32'(cnt) >= tRFC - 32'd1);
      default:       ;
    endcase
  end

  // Power-up wait: needs tINIT consecutive init_req cycles; init_done is sticky.
  always_comb begin
    init_cnt_next  = init_cnt;
    init_done_next = init_done;
    if (!init_done) begin
      if (init_req) begin
        init_cnt_next = init_cnt + INIT_W'(1);
        if (32'(init_cnt) == tINIT - 32'd1) begin
          init_done_next = 1'b1;
        end
      end else begin
        init_cnt_next = '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt       <= '0;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      init_cnt  <= init_cnt_next;
      init_done <= init_done_next;
    end
  end

`ifdef DRAM_TIMING_REFRESH_EN
  localparam int unsigned      REF_W    = $clog2(tREFI) + 1;
  localparam logic [REF_W-1:0] REF_LOAD = REF_W'(tREFI - 1);
  localparam logic [3:0]       PEND_MAX = 4'd8;

  logic [REF_W-1:0] ref_cnt;
  logic [REF_W-1:0] ref_cnt_next;
  logic [3:0]       pend;
  logic [3:0]       pend_next;
  logic             expire;
  logic             complete;

  // Interval countdown runs only after power-up; each expiry adds one owed refresh.
  always_comb begin
    ref_cnt_next = ref_cnt;
    expire       = 1'b0;
    complete     = tREF_done && (ncmd_state != CMD_REFRESH);
    pend_next    = pend;
    if (init_done) begin
      if (ref_cnt == '0) begin
        ref_cnt_next = REF_LOAD;
        expire       = 1'b1;
      end else begin
        ref_cnt_next = ref_cnt - REF_W'(1);
      end
    end
    if (expire && !complete) begin
      pend_next = (pend == PEND_MAX) ? pend : pend + 4'd1;
    end else if (complete && !expire && pend != 4'd0) begin
      pend_next = pend - 4'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ref_cnt <= REF_LOAD;
      pend    <= 4'd0;
      rf_req  <= 1'b0;
    end else begin
      ref_cnt <= ref_cnt_next;
      pend    <= pend_next;
      rf_req  <= (pend != 4'd0);
    end
  end
`else
  assign rf_req = 1'b0;
`endif

endmodule

// File: tb/tb_dram_timing_ctrl.sv
// Bench for dram_timing_ctrl: vector tables, hand sequences and random command traffic
// compared every cycle against a model built on state-entry times and refresh-interval arithmetic.
module tb_dram_timing_ctrl;
  import dram_pack::*;

  localparam int T_INIT = 200;
  localparam int T_RCD  = 4;
  localparam int T_RL   = 8;
  localparam int T_WL   = 10;
  localparam int T_RP   = 4;
  localparam int T_RFC  = 32;
  localparam int T_REFI = 20;

  typedef struct {
    cmd_fsm_t   cmd;
    logic [4:0] done;   // {act, rd, wr, pre, ref}
  } vec_t;

  logic     CLK = 1'b0;
  logic     RST;
  cmd_fsm_t cmd_state;
  cmd_fsm_t ncmd_state;
  logic     init_req;
  logic     init_done;
  logic     tACT_done;
  logic     tRD_done;
  logic     tWR_done;
  logic     tPRE_done;
  logic     tREF_done;
  logic     rf_req;
  logic [6:0] dut_vec;
  logic [4:0] dut_done;

  assign dut_done = {tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done};
  assign dut_vec  = {init_done, dut_done, rf_req};

  always #5 CLK = ~CLK;

  dram_timing_ctrl #(
    .tINIT(T_INIT), .tRCD(T_RCD), .tRL(T_RL), .tWL(T_WL),
    .tRP(T_RP), .tRFC(T_RFC), .tREFI(T_REFI)
  ) dut (
    .CLK(CLK), .RST(RST), .cmd_state(cmd_state), .ncmd_state(ncmd_state),
    .init_req(init_req), .init_done(init_done), .tACT_done(tACT_done),
    .tRD_done(tRD_done), .tWR_done(tWR_done), .tPRE_done(tPRE_done),
    .tREF_done(tREF_done), .rf_req(rf_req)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: cycle index, entry cycle of current state, init_req run, refresh debt.
  int       cyc = 0;
  int       entry = 0;
  int       run = 0;
  int       d_cyc = 0;
  int       pend = 0;
  bit       m_idone = 0;
  bit       m_rf = 0;
  bit       have_prev = 0;
  cmd_fsm_t p_cmd = CMD_IDLE;
  cmd_fsm_t p_ncmd = CMD_IDLE;
  bit       p_ireq = 0;
  bit       p_ref_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int t_of(cmd_fsm_t s);
    case (s)
      CMD_ACTIVATE:  return T_RCD;
      CMD_READ:      return T_RL;
      CMD_WRITE:     return T_WL;
      CMD_PRECHARGE: return T_RP;
      CMD_REFRESH:   return T_RFC;
      default:       return 0;
    endcase
  endfunction

  function automatic logic [4:0] flags_of(cmd_fsm_t s, int elapsed);
    logic [4:0] f;
    f = '0;
    if (t_of(s) != 0 && elapsed >= t_of(s) - 1) begin
      case (s)
        CMD_ACTIVATE:  f = 5'b10000;
        CMD_READ:      f = 5'b01000;
        CMD_WRITE:     f = 5'b00100;
        CMD_PRECHARGE: f = 5'b00010;
        CMD_REFRESH:   f = 5'b00001;
        default:       f = '0;
      endcase
    end
    return f;
  endfunction

  // One controller cycle: advance the model over the cycle just ended, drive, then compare.
  task automatic step(input cmd_fsm_t c, input cmd_fsm_t nc, input bit ir);
    bit         expire;
    bit         complete;
    logic [4:0] dv;
    bit         rf_exp;
    @(posedge CLK);
    cyc++;
    if (have_prev) begin
      expire   = m_idone && (cyc > d_cyc) && (((cyc - d_cyc) % T_REFI) == 0);
      complete = p_ref_done && (p_ncmd != CMD_REFRESH);
      m_rf = (pend != 0);
      if (expire && !complete) pend = (pend < 8) ? pend + 1 : 8;
      else if (complete && !expire && pend > 0) pend = pend - 1;
      run = p_ireq ? run + 1 : 0;
      if (!m_idone && run >= T_INIT) begin
        m_idone = 1'b1;
        d_cyc   = cyc;
      end
    end
    have_prev = 1'b1;
    #1;
    if (c != p_cmd) entry = cyc;
    cmd_state  = c;
    ncmd_state = nc;
    init_req   = ir;
    dv = flags_of(c, cyc - entry);
    p_cmd      = c;
    p_ncmd     = nc;
    p_ireq     = ir;
    p_ref_done = dv[0];
`ifdef DRAM_TIMING_REFRESH_EN
    rf_exp = m_rf;
`else
    rf_exp = 1'b0;
`endif
    #3;
    check("cycle_outputs", 32'(dut_vec), 32'({m_idone, dv, rf_exp}));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    check("reset_async", 32'(dut_vec), 32'd0);
    cmd_state  = CMD_IDLE;
    ncmd_state = CMD_IDLE;
    init_req   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    cyc++;
    have_prev = 1'b1;
    p_cmd = CMD_IDLE; p_ncmd = CMD_IDLE; p_ireq = 1'b0; p_ref_done = 1'b0;
    run = 0; pend = 0; m_idone = 1'b0; m_rf = 1'b0; entry = cyc; d_cyc = 0;
  endtask

  task automatic play(input cmd_fsm_t q[$], input bit rnd_req);
    bit ir;
    for (int i = 0; i < q.size(); i++) begin
      ir = rnd_req ? ($urandom_range(0, 99) < 98) : 1'b1;
      step(q[i], (i + 1 < q.size()) ? q[i+1] : q[i], ir);
    end
  endtask

  // Hold init_req from reset; report rf_req first rise relative to init_done rise.
  task automatic init_watch(output int rise);
    int first_rf;
    first_rf = -1;
    for (int i = 0; i < T_INIT + 45; i++) begin
      step(CMD_IDLE, CMD_IDLE, 1'b1);
      if (i == T_INIT - 1) check("init_still_low", 32'(init_done), 32'd0);
      if (i == T_INIT)     check("init_rises", 32'(init_done), 32'd1);
      if (rf_req === 1'b1 && first_rf < 0) first_rf = cyc;
    end
    rise = (first_rf < 0) ? -1 : first_rf - d_cyc;
  endtask

  task automatic check_refresh_rise(input int rise);
`ifdef DRAM_TIMING_REFRESH_EN
    check("rf_first_rise", 32'(rise), 32'(T_REFI + 1));
    check("rf_owed_after_45", 32'(rf_req), 32'd1);
`else
    check("rf_never_rises", 32'(rise), 32'(-1));
    check("rf_tied_low", 32'(rf_req), 32'd0);
`endif
  endtask

  initial begin
    cmd_fsm_t q[$];
    vec_t     tbl[$];
    cmd_fsm_t cur;
    cmd_fsm_t s;
    int       rise;
    int       n;
    int       len;

    RST = 1'b0;
    cmd_state = CMD_IDLE;
    ncmd_state = CMD_IDLE;
    init_req = 1'b0;
    #2;
    do_reset();

    // Power-up wait and first refresh interval.
    init_watch(rise);
    check_refresh_rise(rise);

    // One full refresh, then a refresh whose completion lands on an interval expiry.
    q.delete();
    q.push_back(CMD_IDLE);
    repeat (T_RFC) q.push_back(CMD_REFRESH);
    q.push_back(CMD_IDLE);
    play(q, 1'b0);
    n = 1;
    while (((cyc + n + 1 + T_RFC - d_cyc) % T_REFI) != 0) n++;
    q.delete();
    repeat (n) q.push_back(CMD_IDLE);
    repeat (T_RFC) q.push_back(CMD_REFRESH);
    repeat (3) q.push_back(CMD_IDLE);
    play(q, 1'b0);

    // Vector tables: ACTIVATE held 6 cycles, then ACT(4)/READ(8)/PRECHARGE(4).
    tbl.push_back(vec_t'{CMD_IDLE, 5'b00000});
    for (int i = 0; i < 6; i++) tbl.push_back(vec_t'{CMD_ACTIVATE, (i >= 3) ? 5'b10000 : 5'b00000});
    tbl.push_back(vec_t'{CMD_IDLE, 5'b00000});
    for (int i = 0; i < 4; i++) tbl.push_back(vec_t'{CMD_ACTIVATE, (i == 3) ? 5'b10000 : 5'b00000});
    for (int i = 0; i < 8; i++) tbl.push_back(vec_t'{CMD_READ, (i == 7) ? 5'b01000 : 5'b00000});
    for (int i = 0; i < 4; i++) tbl.push_back(vec_t'{CMD_PRECHARGE, (i == 3) ? 5'b00010 : 5'b00000});
    tbl.push_back(vec_t'{CMD_IDLE, 5'b00000});
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].cmd, (i + 1 < tbl.size()) ? tbl[i+1].cmd : tbl[i].cmd, 1'b1);
      check("tbl_done", 32'(dut_done), 32'(tbl[i].done));
    end

    // READ, one-cycle IDLE excursion, READ again: timing must restart.
    q.delete();
    q.push_back(CMD_IDLE);
    repeat (T_RL) q.push_back(CMD_READ);
    q.push_back(CMD_IDLE);
    repeat (T_RL) q.push_back(CMD_READ);
    q.push_back(CMD_IDLE);
    for (int i = 0; i < q.size(); i++) begin
      step(q[i], (i + 1 < q.size()) ? q[i+1] : q[i], 1'b1);
      if (i >= 10 && i <= 17) check("reentry_rd", 32'(tRD_done), 32'(i == 17));
    end

    // Reset in the middle of a stalled WRITE with refresh debt outstanding.
    q.delete();
    q.push_back(CMD_IDLE);
    repeat (T_WL + 2) q.push_back(CMD_WRITE);
    play(q, 1'b0);
    check("wr_before_rst", 32'(tWR_done), 32'd1);
    do_reset();
    init_watch(rise);
    check_refresh_rise(rise);

    // init_req dropped for one cycle at cycle 100 restarts the wait.
    do_reset();
    for (int i = 0; i < 302; i++) begin
      step(CMD_IDLE, CMD_IDLE, i != 100);
      if (i == 300) check("init_restart_low", 32'(init_done), 32'd0);
      if (i == 301) check("init_restart_high", 32'(init_done), 32'd1);
    end

    // Random command traffic, first with a flaky init_req, then steady.
    do_reset();
    for (int phase = 0; phase < 2; phase++) begin
      q.delete();
      q.push_back(CMD_IDLE);
      cur = CMD_IDLE;
      while (q.size() < ((phase == 0) ? 500 : 1500)) begin
        do s = cmd_fsm_t'(3'($urandom_range(0, 7))); while (s == cur);
        len = $urandom_range(1, 40);
        repeat (len) q.push_back(s);
        cur = s;
      end
      if (cur != CMD_IDLE) q.push_back(CMD_IDLE);
      play(q, phase == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
